// File: rtl/alu_pkg.sv
// alu_pkg: ALU_op codes, MIPS32 opcode/funct/sa constants and the issue_t record.
package alu_pkg;
    localparam int DW = 32;
    localparam int RW = 5;

    localparam logic [3:0] ALU_ADDU = 4'd0;
    localparam logic [3:0] ALU_SUBU = 4'd1;
    localparam logic [3:0] ALU_CLZ  = 4'd2;
    localparam logic [3:0] ALU_CLO  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_NOR  = 4'd8;
    localparam logic [3:0] ALU_XOR  = 4'd9;
    localparam logic [3:0] ALU_SEB  = 4'd10;
    localparam logic [3:0] ALU_SEH  = 4'd11;
    localparam logic [3:0] ALU_ADD  = 4'd14;
    localparam logic [3:0] ALU_SUB  = 4'd15;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_SLTI     = 6'h0A;
    localparam logic [5:0] OP_SLTIU    = 6'h0B;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_LUI      = 6'h0F;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_SPECIAL3 = 6'h1F;

    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;
    localparam logic [5:0] F_CLZ   = 6'h20;
    localparam logic [5:0] F_CLO   = 6'h21;
    localparam logic [5:0] F_BSHFL = 6'h20;
    localparam logic [4:0] SA_SEB  = 5'h10;
    localparam logic [4:0] SA_SEH  = 5'h18;

    typedef struct packed {
        logic [3:0]    alu_op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [RW-1:0] dst;
        logic          wen;
        logic          ov_trap;
        logic          illegal;
    } issue_t;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational MIPS32 -> ALU_op/operand/destination decode.
// ALU_ISSUE_CLZ_EN enables SPECIAL2 CLZ/CLO; otherwise they decode as illegal.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [DW-1:0] instr,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    output issue_t        iss
);
    logic [5:0]    opc, funct;
    logic [4:0]    rs, sa;
    logic [RW-1:0] rt, rd;
    logic [15:0]   imm;

    assign opc   = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign sa    = instr[10:6];
    assign funct = instr[5:0];
    assign imm   = instr[15:0];

    always_comb begin
        iss = '0;
        iss.illegal = 1'b0;
        iss.a = rs_data;
        iss.dst = rt;
        case (opc)
            OP_SPECIAL: begin
                iss.b = rt_data;
                iss.dst = rd;
                case (funct)
                    F_ADD:   iss.alu_op = ALU_ADD;
                    F_ADDU:  iss.alu_op = ALU_ADDU;
                    F_SUB:   iss.alu_op = ALU_SUB;
                    F_SUBU:  iss.alu_op = ALU_SUBU;
                    F_AND:   iss.alu_op = ALU_AND;
                    F_OR:    iss.alu_op = ALU_OR;
                    F_XOR:   iss.alu_op = ALU_XOR;
                    F_NOR:   iss.alu_op = ALU_NOR;
                    F_SLT:   iss.alu_op = ALU_SLT;
                    F_SLTU:  iss.alu_op = ALU_SLTU;
                    default: iss.illegal = 1'b1;
                endcase
            end
            OP_ADDI:  {iss.alu_op, iss.b} = {ALU_ADD,  {{16{imm[15]}}, imm}};
            OP_ADDIU: {iss.alu_op, iss.b} = {ALU_ADDU, {{16{imm[15]}}, imm}};
            OP_SLTI:  {iss.alu_op, iss.b} = {ALU_SLT,  {{16{imm[15]}}, imm}};
            OP_SLTIU: {iss.alu_op, iss.b} = {ALU_SLTU, {{16{imm[15]}}, imm}};
            OP_ANDI:  {iss.alu_op, iss.b} = {ALU_AND,  {16'h0, imm}};
            OP_ORI:   {iss.alu_op, iss.b} = {ALU_OR,   {16'h0, imm}};
            OP_XORI:  {iss.alu_op, iss.b} = {ALU_XOR,  {16'h0, imm}};
            OP_LUI:   {iss.alu_op, iss.a, iss.b} = {ALU_OR, {DW{1'b0}}, {imm, 16'h0}};
`ifdef ALU_ISSUE_CLZ_EN
            OP_SPECIAL2: begin
                iss.dst = rd;
                iss.alu_op = funct == F_CLO ? ALU_CLO : ALU_CLZ;
                iss.illegal = funct != F_CLZ && funct != F_CLO;
            end
`endif
            OP_SPECIAL3: begin
                iss.a = '0;
                iss.b = rt_data;
                iss.dst = rd;
                iss.alu_op = sa == SA_SEH ? ALU_SEH : ALU_SEB;
                // BSHFL encodings carry rs = 0; anything else is not SEB/SEH
                iss.illegal = funct != F_BSHFL || rs != '0 || (sa != SA_SEB && sa != SA_SEH);
            end
            default: iss.illegal = 1'b1;
        endcase
        if (iss.illegal) begin
            iss.alu_op = '0;
            iss.a = '0;
            iss.b = '0;
            iss.dst = '0;
        end
        iss.ov_trap = iss.alu_op == ALU_ADD || iss.alu_op == ALU_SUB;
        iss.wen = !iss.illegal && iss.dst != '0;
    end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID->EX issue register with valid/ready handshake and 2-entry skid.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] instr,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_alu_op,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic [RW-1:0] out_dst,
    output logic          out_wen,
    output logic          out_ov_trap,
    output logic          out_illegal
);
    issue_t dec, main_q, main_d, skid_q, skid_d;
    logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d, ready_q, ready_d;
    logic   acc, cons;

    alu_op_decode u_dec (.instr(instr), .rs_data(rs_data), .rt_data(rt_data), .iss(dec));

    always_comb begin
        acc = in_valid && ready_q && !flush;
        cons = main_valid_q && out_ready;
        main_d = main_q;
        main_valid_d = main_valid_q;
        skid_d = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || cons) begin
            // skid is older than any new beat; in_ready is low whenever it is full
            main_d = skid_valid_q ? skid_q : acc ? dec : main_q;
            main_valid_d = skid_valid_q || acc;
            skid_valid_d = 1'b0;
        end else if (acc) begin
            skid_d = dec;
            skid_valid_d = 1'b1;
        end
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q <= ready_d;
        end
    end

    assign in_ready = ready_q;
    assign out_valid = main_valid_q;
    assign out_alu_op = main_q.alu_op;
    assign out_a = main_q.a;
    assign out_b = main_q.b;
    assign out_dst = main_q.dst;
    assign out_wen = main_q.wen;
    assign out_ov_trap = main_q.ov_trap;
    assign out_illegal = main_q.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed decode vectors plus handshake, skid, flush and reset sequences.
module tb_alu_issue_stage;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, flush = 1'b0;
    logic        out_valid, out_ready = 1'b0, out_wen, out_ov_trap, out_illegal;
    logic [31:0] instr = '0, rs_data = '0, rt_data = '0, out_a, out_b;
    logic [3:0]  out_alu_op;
    logic [4:0]  out_dst;
    int          total = 0, passed = 0;

    typedef struct {
        logic [31:0] instr, rs, rt;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [4:0]  dst;
        logic        wen, ov, ill;
    } vec_t;
    vec_t vt[26];

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .rs_data(rs_data), .rt_data(rt_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_alu_op(out_alu_op), .out_a(out_a), .out_b(out_b),
        .out_dst(out_dst), .out_wen(out_wen), .out_ov_trap(out_ov_trap), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        in_valid = v;
        instr = ins;
        rs_data = rs;
        rt_data = rt;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0]  = '{32'h00221820, 5, 7, 14, 5, 7, 3, 1, 1, 0};
        vt[1]  = '{32'h00221821, 5, 7, 0, 5, 7, 3, 1, 0, 0};
        vt[2]  = '{32'h00221822, 5, 7, 15, 5, 7, 3, 1, 1, 0};
        vt[3]  = '{32'h00221823, 5, 7, 1, 5, 7, 3, 1, 0, 0};
        vt[4]  = '{32'h00221824, 5, 7, 4, 5, 7, 3, 1, 0, 0};
        vt[5]  = '{32'h00221825, 5, 7, 6, 5, 7, 3, 1, 0, 0};
        vt[6]  = '{32'h00221826, 5, 7, 9, 5, 7, 3, 1, 0, 0};
        vt[7]  = '{32'h00221827, 5, 7, 8, 5, 7, 3, 1, 0, 0};
        vt[8]  = '{32'h0022182A, 5, 7, 5, 5, 7, 3, 1, 0, 0};
        vt[9]  = '{32'h0022182B, 5, 7, 7, 5, 7, 3, 1, 0, 0};
        vt[10] = '{32'h2424FFFF, 10, 7, 0, 10, 32'hFFFFFFFF, 4, 1, 0, 0};
        vt[11] = '{32'h3C061234, 5, 7, 6, 0, 32'h12340000, 6, 1, 0, 0};
        vt[12] = '{32'h34058000, 32'h11, 7, 6, 32'h11, 32'h00008000, 5, 1, 0, 0};
        vt[13] = '{32'h2024FFF0, 5, 7, 14, 5, 32'hFFFFFFF0, 4, 1, 1, 0};
        vt[14] = '{32'h28248000, 5, 7, 5, 5, 32'hFFFF8000, 4, 1, 0, 0};
        vt[15] = '{32'h2C240005, 5, 7, 7, 5, 5, 4, 1, 0, 0};
        vt[16] = '{32'h3024F0F0, 5, 7, 4, 5, 32'h0000F0F0, 4, 1, 0, 0};
        vt[17] = '{32'h38248001, 5, 7, 9, 5, 32'h00008001, 4, 1, 0, 0};
        vt[18] = '{32'h7C083C20, 5, 32'h80, 10, 0, 32'h80, 7, 1, 0, 0};
        vt[19] = '{32'h7C083E20, 5, 32'h8000, 11, 0, 32'h8000, 7, 1, 0, 0};
        vt[20] = '{32'hFC000000, 5, 7, 0, 0, 0, 0, 0, 0, 1};
        vt[21] = '{32'h00220021, 5, 7, 0, 5, 7, 0, 0, 0, 0};
        vt[22] = '{32'h00221808, 5, 7, 0, 0, 0, 0, 0, 0, 1};
        vt[23] = '{32'h7C083820, 5, 7, 0, 0, 0, 0, 0, 0, 1};
`ifdef ALU_ISSUE_CLZ_EN
        vt[24] = '{32'h70221020, 5, 7, 2, 5, 0, 2, 1, 0, 0};
`else
        vt[24] = '{32'h70221020, 5, 7, 0, 0, 0, 0, 0, 0, 1};
`endif
        vt[25] = '{32'h00220020, 5, 7, 14, 5, 7, 0, 0, 1, 0};

        #1;
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_alu_op", out_alu_op, 0);
        chk("rst out_wen", out_wen, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post-rst in_ready", in_ready, 1);
        chk("post-rst out_valid", out_valid, 0);

        out_ready = 1'b1;
        foreach (vt[i]) begin
            drive(1, vt[i].instr, vt[i].rs, vt[i].rt);
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d valid", i), out_valid, 1);
            chk($sformatf("v%0d op", i), out_alu_op, vt[i].op);
            chk($sformatf("v%0d a", i), out_a, vt[i].a);
            chk($sformatf("v%0d b", i), out_b, vt[i].b);
            chk($sformatf("v%0d dst", i), out_dst, vt[i].dst);
            chk($sformatf("v%0d wen", i), out_wen, vt[i].wen);
            chk($sformatf("v%0d ov", i), out_ov_trap, vt[i].ov);
            chk($sformatf("v%0d ill", i), out_illegal, vt[i].ill);
        end

        // back-to-back with out_ready high: main is replaced every cycle
        drive(1, 32'h00221820, 5, 7);
        tick();
        chk("stream0 op", out_alu_op, 14);
        drive(1, 32'h00221823, 5, 7);
        tick();
        chk("stream1 valid", out_valid, 1);
        chk("stream1 op", out_alu_op, 1);
        chk("stream1 in_ready", in_ready, 1);
        drive(0, 0, 0, 0);
        tick();
        chk("stream drained", out_valid, 0);

        // backpressure: third beat refused, then in-order drain
        out_ready = 1'b0;
        drive(1, 32'h00221820, 5, 7);
        tick();
        chk("bp0 in_ready", in_ready, 1);
        drive(1, 32'h00221823, 5, 7);
        tick();
        chk("bp1 in_ready", in_ready, 0);
        chk("bp1 op held", out_alu_op, 14);
        drive(1, 32'h00221826, 5, 7);
        tick();
        chk("bp2 in_ready", in_ready, 0);
        chk("bp2 op held", out_alu_op, 14);
        chk("bp2 valid", out_valid, 1);
        drive(0, 0, 0, 0);
        out_ready = 1'b1;
        tick();
        chk("drain0 valid", out_valid, 1);
        chk("drain0 op", out_alu_op, 1);
        chk("drain0 in_ready", in_ready, 1);
        tick();
        chk("drain1 valid", out_valid, 0);

        // flush with main and skid full; concurrent in_valid ignored
        out_ready = 1'b0;
        drive(1, 32'h00221820, 5, 7);
        tick();
        drive(1, 32'h00221823, 5, 7);
        tick();
        chk("pre-flush in_ready", in_ready, 0);
        drive(1, 32'h00221826, 5, 7);
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("flush out_valid", out_valid, 0);
        chk("flush in_ready", in_ready, 1);
        drive(1, 32'h00221824, 5, 7);
        flush = 1'b0;
        tick();
        chk("post-flush valid", out_valid, 1);
        chk("post-flush op", out_alu_op, 4);
        drive(0, 0, 0, 0);
        tick();
        chk("post-flush drained", out_valid, 0);

        // asynchronous reset mid-operation
        out_ready = 1'b0;
        drive(1, 32'h00221820, 5, 7);
        tick();
        drive(1, 32'h00221823, 5, 7);
        tick();
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("midrst out_valid", out_valid, 0);
        chk("midrst in_ready", in_ready, 0);
        chk("midrst op", out_alu_op, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("midrst release in_ready", in_ready, 1);
        chk("midrst release valid", out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
